mem_port_arbiter: RTL and testbench

//  Shares the single 64x8 program/data memory between the CPU and a loader/dump

---
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared program/data memory between the CPU and the loader/dump port.
// CPU wins by default; a burst counter hands the memory to a waiting loader periodically.
module mem_port_arbiter #(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_adr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_adr,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic              ld_lock,
    output logic              ld_gnt,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_rvalid,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    localparam int              CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_LD   = 2'd2
    } owner_t;

    owner_t             owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  ld_rdata_q, ld_rdata_d;
    logic               ld_rvalid_q, ld_rvalid_d;
    logic               err_q, err_d;

    logic               cpu_req;
    logic               ld_win;
    logic               gnt_cpu;
    logic               gnt_ld;
    logic [CNT_W-1:0]   cnt_run;

    // Grants are gated by rst so nothing can reach the memory while reset is held.
    always_comb begin
        cpu_req = cpu_rd | cpu_wr;
        ld_win  = ld_req & (ld_lock | ~cpu_req | (cnt_q == CNT_MAX));
        gnt_ld  = rst & ld_win;
        gnt_cpu = rst & cpu_req & ~ld_win & ~ld_lock;
    end

    always_comb begin
        owner_d = OWN_IDLE;
        if (gnt_ld) begin
            owner_d = OWN_LD;
        end else if (gnt_cpu) begin
            owner_d = OWN_CPU;
        end

        // The counter only carries a run of back-to-back CPU grants.
        cnt_run = (owner_q == OWN_CPU) ? cnt_q : '0;
        cnt_d   = cnt_q;
        if (!ld_req || gnt_ld) begin
            cnt_d = '0;
        end else if (gnt_cpu) begin
            cnt_d = (cnt_run == CNT_MAX) ? cnt_run : cnt_run + 1'b1;
        end

        ld_rvalid_d = gnt_ld & ~ld_we;
        ld_rdata_d  = (gnt_ld & ~ld_we) ? mem_rdata : ld_rdata_q;
        err_d       = err_q | (cpu_rd & cpu_wr);
    end

    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_adr   = '0;
        mem_wdata = '0;
        cpu_rdata = '0;
        if (gnt_ld) begin
            mem_adr   = ld_adr;
            mem_wdata = ld_wdata;
            mem_wr    = ld_we;
            mem_rd    = ~ld_we;
        end else if (gnt_cpu) begin
            mem_adr   = cpu_adr;
            mem_wdata = cpu_wdata;
            mem_wr    = cpu_wr;
            mem_rd    = cpu_rd & ~cpu_wr;
            cpu_rdata = cpu_rd ? mem_rdata : '0;
        end
        ld_gnt    = gnt_ld;
        cpu_stall = rst & cpu_req & ~gnt_cpu;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_q     <= OWN_IDLE;
            cnt_q       <= '0;
            ld_rdata_q  <= '0;
            ld_rvalid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            ld_rdata_q  <= ld_rdata_d;
            ld_rvalid_q <= ld_rvalid_d;
            err_q       <= err_d;
        end
    end

    assign ld_rdata  = ld_rdata_q;
    assign ld_rvalid = ld_rvalid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory model, per-cycle reference model compare,
// and directed scenarios with literal expectations.
module tb_mem_port_arbiter;

    localparam int AW = 6;
    localparam int DW = 8;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_rd, cpu_wr;
    logic [AW-1:0] cpu_adr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_stall;
    logic          ld_req, ld_we, ld_lock, ld_gnt, ld_rvalid;
    logic [AW-1:0] ld_adr;
    logic [DW-1:0] ld_wdata, ld_rdata;
    logic          mem_rd, mem_wr, err;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic [DW-1:0] mem     [64];
    logic [DW-1:0] ref_mem [64];

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ld_req(ld_req), .ld_we(ld_we), .ld_adr(ld_adr), .ld_wdata(ld_wdata),
        .ld_lock(ld_lock), .ld_gnt(ld_gnt), .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .err(err)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_adr];
    always @(posedge clk) begin
        if (mem_wr) mem[mem_adr] <= mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: run length of CPU grants seen by a waiting loader, plus memory image.
    int            m_run = 0;
    logic          m_err = 1'b0, m_rv = 1'b0;
    logic [DW-1:0] m_ldr = '0;
    bit            m_valid = 1'b0;
    bit            e_ld, e_cpu, e_req;
    logic          e_rd, e_wr;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_wd, e_crd;

    task automatic model_step();
        e_req = cpu_rd | cpu_wr;
        e_ld  = 1'b0;
        e_cpu = 1'b0;
        if (rst) begin
            if (ld_req && (ld_lock || !e_req || m_run >= MB)) e_ld = 1'b1;
            else if (e_req && !ld_lock)                      e_cpu = 1'b1;
        end
        e_rd = 1'b0; e_wr = 1'b0; e_adr = '0; e_wd = '0; e_crd = '0;
        if (e_ld) begin
            e_wr = ld_we; e_rd = !ld_we; e_adr = ld_adr; e_wd = ld_wdata;
        end else if (e_cpu) begin
            e_wr = cpu_wr; e_rd = cpu_rd && !cpu_wr; e_adr = cpu_adr; e_wd = cpu_wdata;
            e_crd = cpu_rd ? ref_mem[cpu_adr] : '0;
        end
        check("mdl_mem_rd", 32'(mem_rd), 32'(e_rd));
        check("mdl_mem_wr", 32'(mem_wr), 32'(e_wr));
        check("mdl_ld_gnt", 32'(ld_gnt), 32'(e_ld));
        check("mdl_cpu_stall", 32'(cpu_stall), 32'(rst && e_req && !e_cpu));
        if (rst) begin
            check("mdl_mem_adr", 32'(mem_adr), 32'(e_adr));
            check("mdl_mem_wdata", 32'(mem_wdata), 32'(e_wd));
            check("mdl_cpu_rdata", 32'(cpu_rdata), 32'(e_crd));
        end
        if (m_valid) begin
            check("mdl_ld_rvalid", 32'(ld_rvalid), 32'(m_rv));
            check("mdl_ld_rdata", 32'(ld_rdata), 32'(m_ldr));
            check("mdl_err", 32'(err), 32'(m_err));
        end
        if (!rst) begin
            m_run = 0; m_err = 1'b0; m_rv = 1'b0; m_ldr = '0; m_valid = 1'b1;
        end else begin
            m_rv = 1'b0;
            if (cpu_rd && cpu_wr) m_err = 1'b1;
            if (e_ld) begin
                m_run = 0;
                if (ld_we) ref_mem[ld_adr] = ld_wdata;
                else begin
                    m_rv  = 1'b1;
                    m_ldr = ref_mem[ld_adr];
                end
            end else if (e_cpu) begin
                m_run = ld_req ? m_run + 1 : 0;
                if (cpu_wr) ref_mem[cpu_adr] = cpu_wdata;
            end
            if (!ld_req) m_run = 0;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_step();
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_adr = '0; cpu_wdata = '0;
        ld_req = 1'b0; ld_we = 1'b0; ld_adr = '0; ld_wdata = '0; ld_lock = 1'b0;
    endtask

    initial begin
        int gcnt, scnt, bad;
        logic [11:0] gv, rv;
        logic [4:0]  pv;
        for (int i = 0; i < 64; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        rst = 1'b0;
        idle();
        cyc();
        cyc();
        #3;
        check("rst_ld_rvalid", 32'(ld_rvalid), 32'd0);
        check("rst_ld_rdata", 32'(ld_rdata), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // Boot load under lock while the CPU keeps requesting.
        gcnt = 0; scnt = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            rst = 1'b1;
            ld_lock = 1'b1; ld_req = 1'b1; ld_we = 1'b1;
            ld_adr = 6'(i); ld_wdata = 8'(i) ^ 8'h2F;
            cpu_rd = 1'b1; cpu_adr = 6'd7;
            #3;
            gcnt += int'(ld_gnt);
            scnt += int'(cpu_stall);
        end
        cyc();
        idle();
        #3;
        check("boot_gnt_count", 32'(gcnt), 32'd40);
        check("boot_stall_count", 32'(scnt), 32'd40);
        bad = 0;
        for (int i = 0; i < 40; i++) if (mem[i] !== (8'(i) ^ 8'h2F)) bad++;
        check("boot_mem_bad_words", 32'(bad), 32'd0);

        // Lock without request blocks the CPU.
        cyc();
        ld_lock = 1'b1; cpu_rd = 1'b1; cpu_adr = 6'd3;
        #3;
        check("lock_only_stall", 32'(cpu_stall), 32'd1);
        check("lock_only_mem_rd", 32'(mem_rd), 32'd0);

        // CPU-only read, zero latency.
        cyc();
        idle();
        cpu_rd = 1'b1; cpu_adr = 6'd5;
        #3;
        check("cpu_rdata_5", 32'(cpu_rdata), 32'h2A);
        check("cpu_only_stall", 32'(cpu_stall), 32'd0);
        check("cpu_only_ld_gnt", 32'(ld_gnt), 32'd0);

        // Contention: 4 CPU grants, then 1 loader grant.
        for (int k = 0; k < 12; k++) begin
            cyc();
            cpu_rd = 1'b1; cpu_adr = 6'(k);
            ld_req = 1'b1; ld_we = 1'b0; ld_adr = 6'd32;
            #3;
            gv[k] = ld_gnt;
            rv[k] = ld_rvalid;
            if (ld_rvalid) check("contend_ld_rdata", 32'(ld_rdata), 32'h0F);
        end
        check("contend_gnt_pattern", 32'(gv), 32'h210);
        check("contend_rvalid_pattern", 32'(rv), 32'h420);

        // Simultaneous first request from idle.
        cyc();
        idle();
        cyc();
        cpu_wr = 1'b1; cpu_adr = 6'd33; cpu_wdata = 8'd13;
        ld_req = 1'b1; ld_we = 1'b0; ld_adr = 6'd34;
        #3;
        check("sim_first_ld_gnt", 32'(ld_gnt), 32'd0);
        check("sim_first_mem_wr", 32'(mem_wr), 32'd1);
        cyc();
        cpu_wr = 1'b0;
        #3;
        check("sim_next_ld_gnt", 32'(ld_gnt), 32'd1);
        cyc();
        idle();
        #3;
        check("sim_ld_rvalid", 32'(ld_rvalid), 32'd1);
        check("sim_ld_rdata", 32'(ld_rdata), 32'h0D);
        check("sim_mem33", 32'(mem[33]), 32'd13);

        // Read and write together: treated as a write, sticky error.
        cyc();
        cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_adr = 6'd10; cpu_wdata = 8'h55;
        #3;
        check("rw_mem_rd", 32'(mem_rd), 32'd0);
        cyc();
        idle();
        #3;
        check("rw_mem10", 32'(mem[10]), 32'h55);
        check("rw_err", 32'(err), 32'd1);
        repeat (3) cyc();
        #3;
        check("rw_err_sticky", 32'(err), 32'd1);

        // Reset in the middle of a CPU burst with a write pending.
        for (int k = 0; k < 3; k++) begin
            cyc();
            cpu_wr = 1'b1; cpu_adr = 6'd20; cpu_wdata = 8'h31 + 8'(k);
            ld_req = 1'b1; ld_we = 1'b0; ld_adr = 6'd0;
            #3;
            check("burst_pre_ld_gnt", 32'(ld_gnt), 32'd0);
        end
        cyc();
        rst = 1'b0; cpu_wdata = 8'hEE;
        #3;
        check("rstmid_mem_wr", 32'(mem_wr), 32'd0);
        check("rstmid_ld_gnt", 32'(ld_gnt), 32'd0);
        check("rstmid_cpu_stall", 32'(cpu_stall), 32'd0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            rst = 1'b1; cpu_wdata = 8'h41 + 8'(k);
            #3;
            if (k == 0) begin
                check("post_rst_ld_rvalid", 32'(ld_rvalid), 32'd0);
                check("post_rst_ld_rdata", 32'(ld_rdata), 32'd0);
                check("post_rst_err", 32'(err), 32'd0);
                check("post_rst_mem20", 32'(mem[20]), 32'h33);
            end
            pv[k] = ld_gnt;
        end
        check("post_rst_gnt_pattern", 32'(pv), 32'h10);

        cyc();
        idle();
        repeat (3) cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
